gpio_input_capture: RTL and testbench



---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_synchronizer.sv | 40 ++++
 rtl/gpio_input_capture.sv | 146 ++++++++++++++
 tb/tb_gpio_input_capture.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// ----------------------------------------------------------------------------
// gpio_pkg
//
// Purpose: constants shared by the GPIO input-capture and output register
// paths. It holds the pin count, the default synchronizer, debounce
// parameters, and a small helper that sizes the debounce tick counter.
//
// Contents:
//   GPIO_WIDTH             number of GPIO pins
//   GPIO_SYNC_STAGES       default synchronizer depth per pin
//   GPIO_DEBOUNCE_DIV      default sample-tick period in clock cycles
//   GPIO_DEBOUNCE_SAMPLES  default number of equal tick samples to accept a level
//   cnt_width()            counter width able to hold 0..div-1 (at least 1 bit)
// ----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_WIDTH            = 32;
    localparam int GPIO_SYNC_STAGES      = 2;
    localparam int GPIO_DEBOUNCE_DIV     = 16;
    localparam int GPIO_DEBOUNCE_SAMPLES = 3;

    // A divider of 1 still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/gpio_synchronizer.sv
// ----------------------------------------------------------------------------
// gpio_synchronizer
//
// Purpose: a multi-flop synchronizer that brings asynchronous pad inputs into
// the clk domain. Each bit passes through STAGES flops. All flops clear to 0
// on the synchronous active-low reset.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous, active-low reset
//   d      in   WIDTH raw asynchronous inputs
//   q      out  WIDTH synchronized outputs (last flop of the chain)
// ----------------------------------------------------------------------------
module gpio_synchronizer
    import gpio_pkg::*;
#(
    parameter int WIDTH  = GPIO_WIDTH,
    parameter int STAGES = GPIO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // sync_p[0] is the metastability-catching flop; sync_p[STAGES-1] is the
    // settled output.
    logic [STAGES-1:0][WIDTH-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/gpio_input_capture.sv
// ----------------------------------------------------------------------------
// gpio_input_capture
//
// Purpose: the input side of the GPIO block. It synchronizes and debounces
// the pad inputs and detects rising and falling edges on the debounced level.
// It latches enabled edges into a sticky, write-1-to-clear status register
// and drives one masked interrupt line.
//
// Ports:
//   clk_i              in   system clock
//   rst_ni             in   synchronous, active-low reset
//   gpio_pins_i        in   WIDTH raw asynchronous pad inputs
//   gpio_direction_i   in   WIDTH 1 = pin is an output (no edge capture)
//   gpio_rise_en_i     in   WIDTH rising-edge capture enable
//   gpio_fall_en_i     in   WIDTH falling-edge capture enable
//   gpio_irq_mask_i    in   WIDTH 1 = status bit drives gpio_irq_o
//   gpio_irq_clr_i     in   WIDTH one-cycle write-1-to-clear strobe
//   gpio_input_o       out  WIDTH debounced pin level (all pins)
//   gpio_irq_status_o  out  WIDTH sticky edge status
//   gpio_irq_o         out  OR of status & mask
// ----------------------------------------------------------------------------
module gpio_input_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH            = GPIO_WIDTH,
    parameter int SYNC_STAGES      = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_DIV     = GPIO_DEBOUNCE_DIV,
    parameter int DEBOUNCE_SAMPLES = GPIO_DEBOUNCE_SAMPLES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gpio_pins_i,
    input  logic [WIDTH-1:0] gpio_direction_i,
    input  logic [WIDTH-1:0] gpio_rise_en_i,
    input  logic [WIDTH-1:0] gpio_fall_en_i,
    input  logic [WIDTH-1:0] gpio_irq_mask_i,
    input  logic [WIDTH-1:0] gpio_irq_clr_i,
    output logic [WIDTH-1:0] gpio_input_o,
    output logic [WIDTH-1:0] gpio_irq_status_o,
    output logic             gpio_irq_o
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_DIV);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(DEBOUNCE_DIV - 1);

    // ---- stage: pad synchronization ----
    logic [WIDTH-1:0] sync_q;

    gpio_synchronizer #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (gpio_pins_i),
        .q     (sync_q)
    );

    // ---- stage: sample tick ----
    // With DEBOUNCE_DIV = 1, TICK_AT is 0. The counter then never leaves 0,
    // so the tick stays high.
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TICK_AT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---- stage: sample history ----
    // window[0] is the sample being taken at this tick, which is the
    // synchronizer output. window[i] is the sample from i ticks earlier. Only
    // the older DEBOUNCE_SAMPLES-1 entries need storage. The newest entry is
    // combinational, so an accepted level appears on the same tick edge that
    // completes the run of equal samples.
    logic [DEBOUNCE_SAMPLES-1:0][WIDTH-1:0] window;

    generate
        if (DEBOUNCE_SAMPLES > 1) begin : g_hist
            logic [DEBOUNCE_SAMPLES-2:0][WIDTH-1:0] hist_p;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    hist_p <= '0;
                end else if (tick) begin
                    hist_p <= window[DEBOUNCE_SAMPLES-2:0];
                end
            end

            assign window = {hist_p, sync_q};
        end else begin : g_no_hist
            assign window = sync_q;
        end
    endgenerate

    // ---- stage: debounce, edge detect, status ----
    logic [WIDTH-1:0] all_high;
    logic [WIDTH-1:0] all_low;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] status_set;

    always_comb begin
        all_high = '1;
        all_low  = '1;
        for (int i = 0; i < DEBOUNCE_SAMPLES; i++) begin
            all_high &= window[i];
            all_low  &= ~window[i];
        end

        // On a tick, a bit whose window is unanimous takes that value. Other
        // bits hold.
        level_next = gpio_input_o;
        if (tick) begin
            level_next = (gpio_input_o | all_high) & ~all_low;
        end

        rise       = level_next & ~gpio_input_o;
        fall       = ~level_next & gpio_input_o;
        status_set = ((rise & gpio_rise_en_i) | (fall & gpio_fall_en_i))
                     & ~gpio_direction_i;
    end

    // A set is ORed in after the clear is applied, so a set on the same edge
    // as a clear leaves the bit at 1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gpio_input_o      <= '0;
            gpio_irq_status_o <= '0;
        end else begin
            gpio_input_o      <= level_next;
            gpio_irq_status_o <= (gpio_irq_status_o & ~gpio_irq_clr_i) | status_set;
        end
    end

    assign gpio_irq_o = |(gpio_irq_status_o & gpio_irq_mask_i);

endmodule

// File: tb/tb_gpio_input_capture.sv
// ----------------------------------------------------------------------------
// tb_gpio_input_capture
//
// Two instances share one set of inputs. A fast instance (DIV=1, SAMPLES=1)
// and a slow instance (DIV=4, SAMPLES=3) are each compared every cycle
// against a behavioural model. The model is written in terms of edge counts
// since reset and lists of tick samples. Directed phases pin known values,
// and a randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_gpio_input_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pins, dir, rise_en, fall_en, mask, clr;
    logic [31:0] in_f, st_f, in_s, st_s;
    logic        irq_f, irq_s;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    gpio_input_capture #(
        .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_DIV(1), .DEBOUNCE_SAMPLES(1)
    ) dut_fast (
        .clk_i(clk), .rst_ni(rst_n), .gpio_pins_i(pins),
        .gpio_direction_i(dir), .gpio_rise_en_i(rise_en),
        .gpio_fall_en_i(fall_en), .gpio_irq_mask_i(mask),
        .gpio_irq_clr_i(clr), .gpio_input_o(in_f),
        .gpio_irq_status_o(st_f), .gpio_irq_o(irq_f)
    );

    gpio_input_capture #(
        .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_DIV(4), .DEBOUNCE_SAMPLES(3)
    ) dut_slow (
        .clk_i(clk), .rst_ni(rst_n), .gpio_pins_i(pins),
        .gpio_direction_i(dir), .gpio_rise_en_i(rise_en),
        .gpio_fall_en_i(fall_en), .gpio_irq_mask_i(mask),
        .gpio_irq_clr_i(clr), .gpio_input_o(in_s),
        .gpio_irq_status_o(st_s), .gpio_irq_o(irq_s)
    );

    // ---------------- behavioural model ----------------
    // pq0/pq1: pin values sampled 1 and 2 edges ago. The synchronized value
    // seen at an edge is the pin value from 2 edges earlier.
    logic [31:0] pq0 = '0, pq1 = '0;
    int unsigned ecnt [2];
    logic [31:0] samp [2][3];   // most recent tick samples, [0] newest
    logic [31:0] lvl  [2];
    logic [31:0] st   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int div, input int ns, input logic [31:0] sv);
        logic [31:0] hi, lo, nl, r, f;
        if (!rst_n) begin
            ecnt[k] = 0;
            for (int i = 0; i < 3; i++) samp[k][i] = '0;
            lvl[k] = '0;
            st[k]  = '0;
        end else begin
            ecnt[k]++;
            nl = lvl[k];
            // A tick falls on every div-th edge after reset release.
            if (ecnt[k] % div == 0) begin
                samp[k][2] = samp[k][1];
                samp[k][1] = samp[k][0];
                samp[k][0] = sv;
                hi = '1;
                lo = '1;
                for (int i = 0; i < ns; i++) begin
                    hi &= samp[k][i];
                    lo &= ~samp[k][i];
                end
                for (int b = 0; b < 32; b++) begin
                    if (hi[b]) nl[b] = 1'b1;
                    else if (lo[b]) nl[b] = 1'b0;
                end
            end
            r = nl & ~lvl[k];
            f = lvl[k] & ~nl;
            st[k]  = (st[k] & ~clr) | (((r & rise_en) | (f & fall_en)) & ~dir);
            lvl[k] = nl;
        end
    endtask

    always @(posedge clk) begin : model_blk
        logic [31:0] sv;
        sv = pq1;
        if (!rst_n) begin
            pq1 = '0;
            pq0 = '0;
        end else begin
            pq1 = pq0;
            pq0 = pins;
        end
        model_step(0, 1, 1, sv);
        model_step(1, 4, 3, sv);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("m_fast_input",  in_f, lvl[0]);
            check("m_fast_status", st_f, st[0]);
            check("m_fast_irq",    {31'b0, irq_f}, {31'b0, |(st[0] & mask)});
            check("m_slow_input",  in_s, lvl[1]);
            check("m_slow_status", st_s, st[1]);
            check("m_slow_irq",    {31'b0, irq_s}, {31'b0, |(st[1] & mask)});
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr(input logic [31:0] v);
        clr = v;
        cyc(1);
        clr = '0;
    endtask

    initial begin
        int waited;
        int rate;
        logic [31:0] flip;

        rst_n = 1'b0; pins = '0; dir = '0; rise_en = '1; fall_en = '0;
        mask = '1; clr = '0;
        cyc(3);
        started = 1'b1;
        check("reset_in_f",  in_f, 32'h0);
        check("reset_st_f",  st_f, 32'h0);
        check("reset_irq_f", {31'b0, irq_f}, 32'h0);
        check("reset_in_s",  in_s, 32'h0);
        check("reset_st_s",  st_s, 32'h0);
        check("reset_irq_s", {31'b0, irq_s}, 32'h0);

        // Basic capture: pin 0 is set up before edge 1 and lands at edge 3.
        rst_n = 1'b1;
        pins  = 32'h1;
        cyc(2);
        check("basic_before_edge3", in_f, 32'h0);
        cyc(1);
        check("basic_input",  in_f, 32'h1);
        check("basic_status", st_f, 32'h1);
        check("basic_irq",    {31'b0, irq_f}, 32'h1);
        cyc(12);
        check("slow_first_level", in_s, 32'h1);
        check("slow_first_rise",  st_s, 32'h1);
        pulse_clr('1);
        check("clr_all_fast", st_f, 32'h0);
        check("clr_all_slow", st_s, 32'h0);
        check("clr_irq_slow", {31'b0, irq_s}, 32'h0);

        // Glitch: pin 5 is high for 6 cycles, shorter than (3-1)*4.
        pins = 32'h21;
        cyc(6);
        pins = 32'h1;
        cyc(20);
        check("glitch_slow_input",  in_s, 32'h1);
        check("glitch_slow_status", st_s, 32'h0);
        check("glitch_fast_status", st_f, 32'h20);
        pulse_clr('1);

        // Pin 5 held high must be accepted within 2 + 4*3 + 1 cycles.
        pins   = 32'h21;
        waited = 0;
        while (!in_s[5] && waited < 15) begin
            cyc(1);
            waited++;
        end
        check("held_slow_input",  in_s, 32'h21);
        check("held_slow_status", st_s, 32'h20);
        pulse_clr('1);

        // Fall-only capture on pin 3.
        rise_en = '0; fall_en = 32'h8;
        pins = 32'h29;
        cyc(20);
        check("fallonly_hi_in_s", in_s, 32'h29);
        check("fallonly_hi_st_s", st_s, 32'h0);
        check("fallonly_hi_st_f", st_f, 32'h0);
        pins = 32'h21;
        cyc(20);
        check("fallonly_lo_st_s", st_s, 32'h8);
        check("fallonly_lo_st_f", st_f, 32'h8);
        pulse_clr('1);

        // Same toggle with pin 3 configured as an output.
        dir  = 32'h8;
        pins = 32'h29;
        cyc(20);
        check("dir_hi_in_s", in_s, 32'h29);
        pins = 32'h21;
        cyc(20);
        check("dir_lo_in_s", in_s, 32'h21);
        check("dir_st_s",    st_s, 32'h0);
        check("dir_st_f",    st_f, 32'h0);
        dir = '0;

        // W1C on a two-bit status.
        rise_en = '1; fall_en = '0;
        pins = '0;
        cyc(20);
        pulse_clr('1);
        pins = 32'h3;
        cyc(20);
        check("w1c_pre_s", st_s, 32'h3);
        check("w1c_pre_f", st_f, 32'h3);
        pulse_clr(32'h1);
        check("w1c_post_s", st_s, 32'h2);
        check("w1c_post_f", st_f, 32'h2);

        // Set wins: clr[1] lands on the edge where the fast instance sees the rise.
        pins = '0;
        cyc(20);
        pulse_clr('1);
        pins = 32'h2;
        cyc(2);
        clr = 32'h2;
        cyc(1);
        clr = '0;
        check("setwins_fast", st_f, 32'h2);
        cyc(20);
        pulse_clr('1);

        // Masking only hides status from the interrupt line.
        pins = 32'h12;
        cyc(20);
        check("mask_st_s", st_s, 32'h10);
        check("mask_st_f", st_f, 32'h10);
        mask = '0;
        #1;
        check("mask_off_irq_s", {31'b0, irq_s}, 32'h0);
        check("mask_off_irq_f", {31'b0, irq_f}, 32'h0);
        mask = 32'h10;
        #1;
        check("mask_on_irq_s", {31'b0, irq_s}, 32'h1);
        check("mask_on_st_s",  st_s, 32'h10);
        mask = '1;
        pulse_clr('1);

        // Reset during a debounce window with every status bit set.
        pins = '0;
        cyc(20);
        pulse_clr('1);
        pins = '1;
        cyc(20);
        check("allset_st_s", st_s, 32'hFFFF_FFFF);
        check("allset_st_f", st_f, 32'hFFFF_FFFF);
        pins = 32'hFFFF_FF7F;
        cyc(5);
        pins  = '1;
        rst_n = 1'b0;
        cyc(1);
        check("midrst_in_f",  in_f, 32'h0);
        check("midrst_st_f",  st_f, 32'h0);
        check("midrst_irq_f", {31'b0, irq_f}, 32'h0);
        check("midrst_in_s",  in_s, 32'h0);
        check("midrst_st_s",  st_s, 32'h0);
        check("midrst_irq_s", {31'b0, irq_s}, 32'h0);
        rst_n  = 1'b1;
        waited = 0;
        while (in_s != 32'hFFFF_FFFF && waited < 15) begin
            cyc(1);
            waited++;
        end
        check("retrig_in_s", in_s, 32'hFFFF_FFFF);
        check("retrig_st_s", st_s, 32'hFFFF_FFFF);
        check("retrig_st_f", st_f, 32'hFFFF_FFFF);

        // Randomized traffic with the model comparing every cycle.
        rate = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rate = $urandom_range(0, 1);
            flip = $urandom & $urandom & $urandom;
            if (rate != 0) flip = flip & $urandom;
            pins = pins ^ flip;
            if ($urandom_range(0, 49) == 0) begin
                dir     = $urandom;
                rise_en = $urandom;
                fall_en = $urandom;
                mask    = $urandom;
            end
            clr   = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            rst_n = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        clr   = '0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
